dsi_packet_assembler: RTL

//  Sequences the shared ECC/CRC datapath to build one DSI packet at a time from a packet request and a payload stream.

---
 rtl/dsi_packet_assembler_pkg.sv | 56 +++++
 rtl/dsi_packet_assembler_fsm.sv | 98 +++++++++
 rtl/dsi_packet_assembler.sv | 114 +++++++++++
 3 files changed

// File: rtl/dsi_packet_assembler_pkg.sv
// Shared definitions for the DSI packet assembler.
//   state_e      : packet sequencer states
//   CRC_SEED     : initial value of the running payload CRC
//   ecc_calc     : 6-bit Hamming ECC over the 24-bit header {wc_hi, wc_lo, di}
//   crc16_update : folds 1..4 payload bytes (byte 0 first, LSB first) into the CRC
package dsi_packet_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PLD  = 2'd2,
        ST_CRC  = 2'd3
    } state_e;

    localparam logic [15:0] CRC_SEED = 16'hFFFF;
    // x^16 + x^12 + x^5 + 1, bit-reversed for LSB-first shifting
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

    // d[7:0] = DI, d[15:8] = WC lo, d[23:16] = WC hi. ECC bits 7:6 are always 0.
    function automatic logic [7:0] ecc_calc(input logic [23:0] d);
        logic [7:0] e;
        e    = '0;
        e[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
               d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        e[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
               d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        e[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
               d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        e[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
               d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        e[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        e[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return e;
    endfunction

    // last_idx = number of valid bytes - 1; bytes above it are ignored.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc_in,
                                                 input logic [31:0] data,
                                                 input logic [1:0]  last_idx);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (b <= int'(last_idx)) begin
                for (int i = 0; i < 8; i++) begin
                    fb = c[0] ^ data[8*b+i];
                    c  = {1'b0, c[15:1]} ^ (fb ? CRC_POLY_REFL : 16'h0000);
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_packet_assembler_fsm.sv
// Packet sequencer: state register, remaining-byte counter and handshake decode.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   pkt_valid/pkt_ready    request handshake; pkt_long, pkt_wc sampled on accept
//   pld_valid/pld_ready    payload handshake (only open in ST_PLD)
//   out_valid, out_ready   output handshake
//   accept                 request accepted this cycle
//   pld_xfer               payload word transferred this cycle
//   pld_bytes              valid bytes - 1 for the current payload word
//   long_pkt               registered long/short flag
//   state                  current state (also the debug view of the FSM)
module dsi_packet_assembler_fsm
    import dsi_packet_assembler_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pkt_valid,
    input  logic        pkt_long,
    input  logic [15:0] pkt_wc,
    input  logic        pld_valid,
    input  logic        out_ready,
    output logic        pkt_ready,
    output logic        pld_ready,
    output logic        out_valid,
    output logic        accept,
    output logic        pld_xfer,
    output logic [1:0]  pld_bytes,
    output logic        long_pkt,
    output state_e      state
);

    state_e      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic        long_q, long_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            long_q      <= long_d;
        end
    end

    // remaining is never 0 while in ST_PLD, so the subtraction cannot underflow.
    assign pld_bytes = (remaining_q < 16'd4) ? (remaining_q[1:0] - 2'd1) : 2'd3;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        long_d      = long_q;
        pkt_ready   = 1'b0;
        pld_ready   = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        pld_xfer    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    accept      = 1'b1;
                    long_d      = pkt_long;
                    remaining_d = pkt_wc;
                    state_d     = ST_HDR;
                end
            end
            ST_HDR: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!long_q)                  state_d = ST_IDLE;
                    else if (remaining_q == 16'd0) state_d = ST_CRC;
                    else                          state_d = ST_PLD;
                end
            end
            ST_PLD: begin
                out_valid = pld_valid;
                pld_ready = out_ready;
                if (pld_valid && out_ready) begin
                    pld_xfer    = 1'b1;
                    remaining_d = remaining_q - (16'(pld_bytes) + 16'd1);
                    if (remaining_q <= 16'd4) state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign long_pkt = long_q;
    assign state    = state_q;

endmodule

// File: rtl/dsi_packet_assembler.sv
// Builds one DSI packet at a time: 4-byte header (DI, WC lo, WC hi, ECC),
// then for long packets the payload pass-through and a 2-byte CRC word.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   pkt_valid/pkt_ready, pkt_long, pkt_di, pkt_wc   packet request
//   pld_valid/pld_ready, pld_data        32-bit payload stream, byte 0 in [7:0]
//   out_valid/out_ready, out_data, out_bytes, out_last   output word stream
//   busy                                 a packet is in progress
// Handshake: every interface transfers on a cycle where valid & ready are
// both 1. A producer holds valid and its data until that transfer; ready may
// change freely. out_* are decoded from registered state only (plus the
// payload pass-through), so they stay stable while out_ready is low.
module dsi_packet_assembler
    import dsi_packet_assembler_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic        pkt_long,
    input  logic [7:0]  pkt_di,
    input  logic [15:0] pkt_wc,
    input  logic        pld_valid,
    output logic        pld_ready,
    input  logic [31:0] pld_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_bytes,
    output logic        out_last,
    output logic        busy
);

    state_e      state;
    logic        accept;
    logic        pld_xfer;
    logic [1:0]  pld_bytes;
    logic        long_pkt;

    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] crc_q, crc_d;

    dsi_packet_assembler_fsm u_fsm (
        .clk       (clk),
        .reset_n   (reset_n),
        .pkt_valid (pkt_valid),
        .pkt_long  (pkt_long),
        .pkt_wc    (pkt_wc),
        .pld_valid (pld_valid),
        .out_ready (out_ready),
        .pkt_ready (pkt_ready),
        .pld_ready (pld_ready),
        .out_valid (out_valid),
        .accept    (accept),
        .pld_xfer  (pld_xfer),
        .pld_bytes (pld_bytes),
        .long_pkt  (long_pkt),
        .state     (state)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            di_q  <= '0;
            wc_q  <= '0;
            crc_q <= CRC_SEED;
        end else begin
            di_q  <= di_d;
            wc_q  <= wc_d;
            crc_q <= crc_d;
        end
    end

    // Accepting a request restarts the CRC so a packet never inherits
    // the previous packet's remainder.
    always_comb begin
        di_d  = di_q;
        wc_d  = wc_q;
        crc_d = crc_q;
        if (accept) begin
            di_d  = pkt_di;
            wc_d  = pkt_wc;
            crc_d = CRC_SEED;
        end else if (pld_xfer) begin
            crc_d = crc16_update(crc_q, pld_data, pld_bytes);
        end
    end

    always_comb begin
        out_data  = '0;
        out_bytes = '0;
        out_last  = 1'b0;
        unique case (state)
            ST_HDR: begin
                out_data  = {ecc_calc({wc_q, di_q}), wc_q, di_q};
                out_bytes = 2'd3;
                out_last  = !long_pkt;
            end
            ST_PLD: begin
                out_data  = pld_data;
                out_bytes = pld_bytes;
            end
            ST_CRC: begin
                out_data  = {16'h0000, crc_q};
                out_bytes = 2'd1;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule
